// File: rtl/nn_pkg.sv
// Shared definitions for the neural-engine shared-memory block: FSM state
// encoding, host register map and CTRL/STATUS bit positions.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } nn_state_e;

    // Host register offsets (cpu_addr[1:0] when the register window is selected)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYC_LO = 2'd2;
    localparam logic [1:0] REG_CYC_HI = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLEAR  = 2;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_TIMEOUT   = 2;
    localparam int unsigned STAT_COLLISION = 3;

    // Inference cycle counter width
    localparam int unsigned CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nn_ram_1k.sv
// Byte-wide storage shared by the neural engine and the host: one write
// port (arbitrated by the parent) and two independent asynchronous read ports.
module nn_ram_1k #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [7:0]        rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [7:0]        rdata_b_o
);

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];

    // Synchronous write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/nn_shared_mem.sv
// Host/neural-engine shared memory with an inference launch FSM, status and
// cycle-count registers, write-ownership arbitration and a level interrupt.
module nn_shared_mem
    import nn_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 60000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RAM_address,
    input  logic [7:0]        RAM_wd,
    input  logic              RAM_we,
    output logic [7:0]        RAM_rd,
    output logic              run_inference,
    input  logic              ready,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [7:0]        cpu_wd,
    input  logic              cpu_we,
    output logic [7:0]        cpu_rd,
    output logic              irq
);

    nn_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             coll_q, coll_d;
    logic             seen_low_q, seen_low_d;

    logic             neural_owns;
    logic             host_reg_wr;
    logic             host_ram_wr;
    logic             ctrl_wr;
    logic             start_req;
    logic             clear_req;
    logic [CNT_W-1:0] cnt_inc;
    logic             finish_ok;
    logic             timed_out;

    logic             mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]       mem_wdata;
    logic [7:0]       host_ram_rd;
    logic [7:0]       status_val;

    // Host access decode: top address bit selects the register window
    assign host_reg_wr = cpu_we &  cpu_addr[ADDR_W];
    assign host_ram_wr = cpu_we & ~cpu_addr[ADDR_W];
    assign ctrl_wr     = host_reg_wr && (cpu_addr[1:0] == REG_CTRL);
    assign start_req   = ctrl_wr && cpu_wd[CTRL_START];
    assign clear_req   = ctrl_wr && cpu_wd[CTRL_CLEAR];

    // cnt_inc is the count including the current BUSY cycle
    assign cnt_inc     = sat_inc(cnt_q);
    assign finish_ok   = seen_low_q && ready;
    assign timed_out   = 32'(cnt_inc) >= TIMEOUT_CYCLES;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a start request outside IDLE is simply ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_req) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (finish_ok || timed_out) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: start pulse and neural write ownership
    always_comb begin
        run_inference = 1'b0;
        neural_owns   = 1'b0;
        unique case (state_q)
            ST_START: begin
                run_inference = 1'b1;
                neural_owns   = 1'b1;
            end
            ST_BUSY:  neural_owns = 1'b1;
            default:  ;
        endcase
    end

    // Register next-state; clears are applied before sets so a same-cycle set wins
    always_comb begin
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        coll_d     = coll_q;
        seen_low_d = seen_low_q;

        if (ctrl_wr) begin
            irq_en_d = cpu_wd[CTRL_IRQ_EN];
        end
        if (clear_req) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
            coll_d    = 1'b0;
        end
        if (start_req && (state_q == ST_IDLE)) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end

        if (state_q == ST_START) begin
            cnt_d      = '0;
            seen_low_d = 1'b0;
        end
        if (state_q == ST_BUSY) begin
            cnt_d = cnt_inc;
            if (!ready) begin
                seen_low_d = 1'b1;
            end
            if (state_d == ST_DONE) begin
                done_d    = 1'b1;
                // A completed ready handshake takes precedence over the limit
                timeout_d = !finish_ok;
                cyc_d     = cnt_inc;
            end
        end

        if (neural_owns && host_ram_wr) begin
            coll_d = 1'b1;
        end
    end

    // Control/status register storage
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            cyc_q      <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            coll_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            coll_q     <= coll_d;
            seen_low_q <= seen_low_d;
        end
    end

    // Write-port arbitration: the neural side owns writes only while an inference runs
    always_comb begin
        if (neural_owns) begin
            mem_we    = RAM_we;
            mem_waddr = RAM_address;
            mem_wdata = RAM_wd;
        end else begin
            mem_we    = host_ram_wr;
            mem_waddr = cpu_addr[ADDR_W-1:0];
            mem_wdata = cpu_wd;
        end
    end

    nn_ram_1k #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (RAM_address),
        .rdata_a_o (RAM_rd),
        .raddr_b_i (cpu_addr[ADDR_W-1:0]),
        .rdata_b_o (host_ram_rd)
    );

    // STATUS image assembled from the flags and the FSM
    always_comb begin
        status_val                 = '0;
        status_val[STAT_BUSY]      = neural_owns;
        status_val[STAT_DONE]      = done_q;
        status_val[STAT_TIMEOUT]   = timeout_q;
        status_val[STAT_COLLISION] = coll_q;
    end

    // Host read mux; start and clear are write-only pulses and read as zero
    always_comb begin
        cpu_rd = '0;
        if (cpu_addr[ADDR_W]) begin
            unique case (cpu_addr[1:0])
                REG_CTRL:   cpu_rd[CTRL_IRQ_EN] = irq_en_q;
                REG_STATUS: cpu_rd = status_val;
                REG_CYC_LO: cpu_rd = cyc_q[7:0];
                REG_CYC_HI: cpu_rd = cyc_q[15:8];
                default:    cpu_rd = '0;
            endcase
        end else begin
            cpu_rd = host_ram_rd;
        end
    end

    assign irq = done_q & irq_en_q;

endmodule

// File: doc/nn_shared_mem.md
NN_SHARED_MEM -- requirements
Module: nn_shared_mem

Interface
REQ-001 Parameter ADDR_W, default 10, neural-side RAM address width (depth 2^ADDR_W bytes).
REQ-002 Parameter TIMEOUT_CYCLES, default 60000, maximum BUSY duration before abort.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RAM_address  input  10  neural-side byte address.
REQ-006 RAM_wd  input  8  neural-side write data.
REQ-007 RAM_we  input  1  neural-side write enable.
REQ-008 RAM_rd  output  8  neural-side read data, combinational from RAM_address.
REQ-009 run_inference  output  1  start pulse to neural engine.
REQ-010 ready  input  1  neural engine idle/finished flag.
REQ-011 cpu_addr  input  11  host address; bit10=0 selects RAM, bit10=1 selects registers (offset = bits1:0).
REQ-012 cpu_wd  input  8  host write data.
REQ-013 cpu_we  input  1  host write strobe, one access per cycle.
REQ-014 cpu_rd  output  8  host read data, combinational from cpu_addr.
REQ-015 irq  output  1  level interrupt, high while STATUS.done and CTRL.irq_en are both set.

Function
REQ-016 Storage: 1024x8 array; synchronous write, asynchronous read on both ports.
REQ-017 Registers: offset 0 CTRL (bit0 start, write-1 pulse, reads 0; bit1 irq_en, R/W; bit2 clear, write-1 clears done/timeout/collision, reads 0); offset 1 STATUS read-only (bit0 busy, bit1 done, bit2 timeout, bit3 collision); offset 2 CYC_LO; offset 3 CYC_HI.
REQ-018 FSM states IDLE, START, BUSY, DONE.
REQ-019 IDLE -> START on host write of CTRL.start=1; the write also clears done and timeout.
REQ-020 START lasts exactly one cycle with run_inference=1; run_inference is 0 in all other states.
REQ-021 START -> BUSY unconditionally; BUSY waits for ready to be sampled 0 and subsequently 1.
REQ-022 BUSY -> DONE on that 0-then-1 ready sequence; DONE sets STATUS.done and returns to IDLE after one cycle.
REQ-023 BUSY -> DONE with STATUS.timeout=1 and done=1 when the cycle counter reaches TIMEOUT_CYCLES.
REQ-024 Cycle counter: cleared in START, increments each BUSY cycle, saturates at 0xFFFF, copied to CYC_HI:CYC_LO on entry to DONE.
REQ-025 STATUS.busy=1 in START and BUSY.
REQ-026 Ownership: in START/BUSY the neural port owns writes; host RAM writes are dropped and set sticky STATUS.collision; host reads are served.
REQ-027 In IDLE/DONE neural RAM_we is ignored; host owns writes.
REQ-028 CTRL.start written while busy is ignored; no restart, no collision flag.
REQ-029 Same-cycle CTRL.clear and an event setting a status bit: the set wins.
REQ-030 Host reads of registers and neural reads of RAM have no side effects.

Reset
REQ-031 reset forces IDLE; run_inference=0, irq=0, CTRL=0, STATUS=0, CYC=0, counter=0.
REQ-032 Reset mid-inference aborts without a done flag; RAM contents are not cleared.

Structure
REQ-033 Package nn_pkg holds the state enum, register offsets, and CTRL/STATUS bit positions.
REQ-034 Storage is a single sub-module nn_ram_1k (two read ports, one muxed write port); FSM, registers, and arbitration live in nn_shared_mem.

Verification
REQ-035 Host writes 0xA5 to addr 0x010, neural reads 0x010 -> RAM_rd=0xA5 in the same cycle.
REQ-036 Host writes CTRL=0x03; ready drops after 2 cycles and rises after 40 more -> run_inference high for exactly 1 cycle, done=1, irq=1, CYC=0x002A.
REQ-037 During BUSY, host writes 0x11 to 0x020 and neural writes 0x22 to 0x020 -> mem[0x020]=0x22, STATUS=0x09 while busy.
REQ-038 TIMEOUT_CYCLES=100, ready held high -> DONE after 100 BUSY cycles, STATUS=0x06.
REQ-039 Assert reset during BUSY, then restart -> STATUS=0x00 after reset, RAM data intact, new inference completes normally.
REQ-040 Same-cycle CTRL.clear and done set -> done remains 1.
